// File: rtl/priority_bit_iterator.sv
// Priority bit iterator: accepts a word and emits one one-hot beat per set bit
// (or a single zero beat for a zero word). Optional index port: PRIORITY_BIT_ITERATOR_IDX_EN.
module priority_bit_iterator #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk_i,
  input  logic             srst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] data_onehot_o,
  output logic             data_last_o,
  output logic             data_val_o,
  input  logic             data_ready_i
`ifdef PRIORITY_BIT_ITERATOR_IDX_EN
  ,
  output logic [$clog2(WIDTH)-1:0] data_idx_o
`endif
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_residual;

  logic [WIDTH-1:0] w_pick;
  logic [WIDTH-1:0] w_rest;
  logic             w_last;
  logic             w_scan;
  logic             w_in_hs;
  logic             w_out_hs;

`ifdef PRIORITY_BIT_ITERATOR_IDX_EN
  localparam int unsigned IW = $clog2(WIDTH);
  logic [IW-1:0] w_idx;
`endif

  // Later matches overwrite earlier ones, so scan direction selects priority.
  always_comb begin
    w_pick = '0;
`ifdef PRIORITY_BIT_ITERATOR_IDX_EN
    w_idx  = '0;
`endif
    for (int unsigned k = 0; k < WIDTH; k++) begin
      int unsigned i;
      i = (MSB_FIRST != 0) ? k : (WIDTH - 1 - k);
      if (r_residual[i]) begin
        w_pick    = '0;
        w_pick[i] = 1'b1;
`ifdef PRIORITY_BIT_ITERATOR_IDX_EN
        w_idx     = IW'(i);
`endif
      end
    end
  end

  assign w_rest   = r_residual & ~w_pick;
  assign w_last   = (w_rest == '0);
  assign w_scan   = (r_state == SCAN);

  assign data_val_o    = w_scan;
  assign data_onehot_o = w_scan ? w_pick : '0;
  assign data_last_o   = w_scan && w_last;
  assign data_ready_o  = !w_scan || (w_last && data_ready_i);

`ifdef PRIORITY_BIT_ITERATOR_IDX_EN
  assign data_idx_o    = w_scan ? w_idx : '0;
`endif

  assign w_in_hs  = data_val_i && data_ready_o;
  assign w_out_hs = w_scan && data_ready_i;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_state    <= IDLE;
      r_residual <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_hs) begin
            r_residual <= data_i;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          if (w_out_hs) begin
            if (!w_last) begin
              r_residual <= w_rest;
            end else if (w_in_hs) begin
              r_residual <= data_i;
            end else begin
              r_residual <= '0;
              r_state    <= IDLE;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_residual <= '0;
        end
      endcase
    end
  end

endmodule
